// File: rtl/fetch_stage_pkg.sv
// Shared core constants: opcodes, NOP encoding, memory-map regions and fetch types.
// Imported by the fetch stage and its interface.
package fetch_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [3:0]  REGION_BIOS      = 4'h4;
    localparam logic [3:0]  REGION_IMEM      = 4'h1;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BIOS = 2'd1,
        SRC_IMEM = 2'd2
    } src_e;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic src_e region_of(input logic [3:0] nibble);
        case (nibble)
            REGION_BIOS: return SRC_BIOS;
            REGION_IMEM: return SRC_IMEM;
            default:     return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: control inputs, BIOS/IMEM read ports and decode-facing outputs.
// master is the fetch stage itself; slave is the surrounding core and memories.
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [31:0] bios_rdata;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        misalign_err;

    modport master (
        input  stall, redirect_valid, redirect_pc, bios_rdata, imem_rdata,
        output bios_addr, imem_addr, instr, instr_pc, instr_valid, misalign_err
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, bios_rdata, imem_rdata,
        input  bios_addr, imem_addr, instr, instr_pc, instr_valid, misalign_err
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: picks the next PC, addresses the synchronous-read BIOS/IMEM,
// and presents the instruction whose data returns this cycle to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master fif
);

    state_e      state;
    src_e        src_q;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        misalign_q;
    logic        redirect;

    // Redirects are ignored while reset is held so the memories keep reading RESET_PC.
    assign redirect = fif.redirect_valid & rst_n;

    always_comb begin
        next_pc = fetch_pc + 32'd4;
        if (redirect) begin
            next_pc = {fif.redirect_pc[31:2], 2'b00};
        end else if (state == ST_WARM || fif.stall) begin
            next_pc = fetch_pc;
        end
    end

    assign fif.bios_addr = next_pc[13:2];
    assign fif.imem_addr = next_pc[15:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            src_q      <= SRC_BIOS;
            state      <= ST_WARM;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc <= next_pc;
            src_q    <= region_of(next_pc[31:28]);
            state    <= ST_RUN;
            if (fif.redirect_valid && fif.redirect_pc[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // A redirect means the data arriving now is from the wrong path.
    always_comb begin
        fif.instr_valid = (state == ST_RUN) && !fif.redirect_valid && (src_q != SRC_NONE);
        fif.instr       = NOP_INSTR;
        if (fif.instr_valid) begin
            case (src_q)
                SRC_BIOS: fif.instr = fif.bios_rdata;
                SRC_IMEM: fif.instr = fif.imem_rdata;
                default:  fif.instr = NOP_INSTR;
            endcase
        end
    end

    assign fif.instr_pc     = fetch_pc;
    assign fif.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// stall/redirect/reset traffic against a PC-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_stage_if fif();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_warm;
    logic        m_mis;

    logic [31:0] rnd;
    logic [31:0] tgt;
    logic [3:0]  nib;

    function automatic logic [31:0] bios_word(input logic [11:0] a);
        return 32'h1000_0000 + {20'd0, a};
    endfunction

    function automatic logic [31:0] imem_word(input logic [13:0] a);
        return 32'hA5A0_0000 ^ {18'd0, a} ^ {a, 18'd0};
    endfunction

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk) begin
        fif.bios_rdata <= bios_word(fif.bios_addr);
        fif.imem_rdata <= imem_word(fif.imem_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rp);
        logic [31:0] npc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        known;
        @(negedge clk);
        fif.stall          = st;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rp;
        #1;
        known     = (m_pc[31:28] == 4'h4) || (m_pc[31:28] == 4'h1);
        exp_valid = !m_warm && !rv && known;
        if (!exp_valid)
            exp_instr = NOP;
        else if (m_pc[31:28] == 4'h4)
            exp_instr = bios_word(m_pc[13:2]);
        else
            exp_instr = imem_word(m_pc[15:2]);
        if (rv)
            npc = {rp[31:2], 2'b00};
        else if (m_warm || st)
            npc = m_pc;
        else
            npc = m_pc + 32'd4;
        checkOutput("instr_pc", fif.instr_pc, m_pc);
        checkOutput("instr_valid", {31'd0, fif.instr_valid}, {31'd0, exp_valid});
        checkOutput("instr", fif.instr, exp_instr);
        checkOutput("misalign_err", {31'd0, fif.misalign_err}, {31'd0, m_mis});
        checkOutput("bios_addr", {20'd0, fif.bios_addr}, {20'd0, npc[13:2]});
        checkOutput("imem_addr", {18'd0, fif.imem_addr}, {18'd0, npc[15:2]});
        @(posedge clk);
        m_pc   = npc;
        m_warm = 1'b0;
        if (rv && rp[1:0] != 2'b00) m_mis = 1'b1;
    endtask

    // Asynchronous reset mid-cycle with arbitrary inputs, released just before a falling edge.
    task automatic doReset();
        @(negedge clk);
        #1;
        fif.stall          = $urandom_range(0, 1);
        fif.redirect_valid = $urandom_range(0, 1);
        fif.redirect_pc    = $urandom();
        rst_n              = 1'b0;
        #1;
        m_pc   = RST_PC;
        m_warm = 1'b1;
        m_mis  = 1'b0;
        checkOutput("rst_instr_pc", fif.instr_pc, RST_PC);
        checkOutput("rst_valid", {31'd0, fif.instr_valid}, 32'd0);
        checkOutput("rst_instr", fif.instr, NOP);
        checkOutput("rst_bios_addr", {20'd0, fif.bios_addr}, {20'd0, RST_PC[13:2]});
        checkOutput("rst_misalign", {31'd0, fif.misalign_err}, 32'd0);
        @(posedge clk);
        #2;
        checkOutput("rst_hold_pc", fif.instr_pc, RST_PC);
        fif.stall          = 1'b0;
        fif.redirect_valid = 1'b0;
        rst_n              = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        fif.stall          = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 32'd0;
        m_pc   = RST_PC;
        m_warm = 1'b1;
        m_mis  = 1'b0;

        $display("[TB] directed scenarios");
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1000_0040);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1000_0010);
        applyStimulus(1'b0, 1'b0, 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h4000_0100);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1000_0022);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h2000_0000);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                doReset();
            end else begin
                rnd = $urandom();
                case ($urandom_range(0, 3))
                    0:       nib = 4'h4;
                    1:       nib = 4'h1;
                    2:       nib = 4'h2;
                    default: nib = 4'hF;
                endcase
                tgt = {nib, rnd[27:0]};
                if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000: first PC fetched after reset (BIOS base).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hold current fetch and output instruction.
REQ-005 redirect_valid  input  1  control-flow redirect from a later stage.
REQ-006 redirect_pc  input  32  redirect target byte address.
REQ-007 bios_addr  output  12  BIOS word address, next_pc[13:2]; synchronous-read memory.
REQ-008 bios_rdata  input  32  BIOS data, one cycle after bios_addr.
REQ-009 imem_addr  output  14  IMEM word address, next_pc[15:2]; synchronous-read memory.
REQ-010 imem_rdata  input  32  IMEM data, one cycle after imem_addr.
REQ-011 instr  output  32  instruction to control decode.
REQ-012 instr_pc  output  32  PC of instr (fetch_pc register).
REQ-013 instr_valid  output  1  instr is a real, correct-path instruction.
REQ-014 misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-015 fetch_pc register SHALL hold the PC whose memory data is present this cycle.
REQ-016 next_pc SHALL be, in priority order: {redirect_pc[31:2],2'b00} if redirect_valid; fetch_pc if state WARM or stall; fetch_pc+4 otherwise (modulo 2^32, wraps FFFF_FFFC->0000_0000).
REQ-017 bios_addr and imem_addr SHALL be driven combinationally from next_pc every cycle; fetch_pc <= next_pc on each edge.
REQ-018 Source register src_q (2 bits) SHALL latch region of next_pc[31:28] with fetch_pc: 4'h4 -> BIOS, 4'h1 -> IMEM, any other -> NONE.
REQ-019 instr SHALL equal bios_rdata (src_q BIOS) or imem_rdata (src_q IMEM) when instr_valid=1, else 32'h0000_0013 (NOP).
REQ-020 States: WARM (first cycle after reset release; memories not yet read) and RUN; WARM->RUN unconditionally at next edge; RUN has no exit except reset.
REQ-021 instr_valid SHALL be 1 iff state RUN, redirect_valid=0 and src_q!=NONE.
REQ-022 Redirect SHALL kill the output instruction in the same cycle (wrong path); target instruction valid the following cycle (1-cycle penalty).
REQ-023 Stall SHALL hold fetch_pc, src_q, instr_pc; instr stays stable because the same address is re-read.
REQ-024 Redirect and stall in the same cycle: redirect wins; stall ignored for that cycle.
REQ-025 misalign_err SHALL set when redirect_valid=1 and redirect_pc[1:0]!=0; cleared only by reset; fetch uses the word-aligned target.
REQ-026 Fetch in region NONE SHALL continue sequentially with instr_valid=0 (no hang).

Reset
REQ-027 On rst_n low, immediately: fetch_pc=RESET_PC, src_q=BIOS, state=WARM, misalign_err=0.
REQ-028 While in reset: instr_valid=0, instr=NOP, bios_addr=RESET_PC[13:2].
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Structure
REQ-030 NOP encoding, region nibbles (BIOS 4'h4, IMEM 4'h1) and RESET_PC default SHALL live in the shared core constants header with the opcode definitions.
REQ-031 Single flat module; no sub-module; state held in fetch_pc, src_q, state and misalign_err registers only.

Verification
REQ-032 Release reset, BIOS returns mem[i]=32'h1000_0000+i: cycle 0 WARM instr_valid=0; then instr_pc 4000_0000, 4000_0004, 4000_0008 with matching data, valid=1.
REQ-033 Redirect to 1000_0040 at instr_pc 4000_0008: that cycle valid=0, instr=NOP, imem_addr=14'h0010; next cycle instr_pc 1000_0040 from imem_rdata, valid=1.
REQ-034 stall=1 for 3 cycles at instr_pc 1000_0010: instr_pc, instr, valid constant; release -> 1000_0014 next.
REQ-035 stall=1 and redirect to 4000_0100 same cycle: valid=0 that cycle; next cycle instr_pc 4000_0100.
REQ-036 Redirect to 1000_0022: misalign_err=1 and stays 1; next instr_pc 1000_0020; rst_n pulse clears misalign_err, restarts at 4000_0000.
REQ-037 Redirect to 2000_0000: instr_valid=0, instr=NOP for every cycle, instr_pc advancing by 4.
